cell_test_sequencer: RTL and testbench
======================================

# cell_test_sequencer

On-chip sequencer that exhaustively exercises one 3-input inverting cell-under-test (CUT) from the standard-cell library, wired as NAND3 with inputs i0/i1/i2 and output nq. It drives all 8 input vectors in order, waits a programmable settle time, samples the CUT output, and counts mismatches against the NAND3 truth table. It sits between the test-control register bank and the CUT instance in the library characterisation macro.

## Interface

- SETTLE_W, default 4: width of settle-time input.
- ERRCNT_W, default 4: width of saturating mismatch counter.

- ck  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate the current run.
- settle  in  SETTLE_W  extra wait cycles per vector; latched on start.
- dut_i0, dut_i1, dut_i2  out  1 each  registered CUT drive; vector v maps as {i2,i1,i0} = v.
- dut_nq  in  1  CUT output.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at run completion.
- pass  out  1  1 when the last completed run had zero mismatches.
- errcnt  out  ERRCNT_W  saturating mismatch count.
- fail_map  out  8  per-vector failure bits; present only with CELL_TEST_SEQ_FAILMAP_EN.

## Operation

- States are IDLE, SETTLE, CHECK and DONE. Reset enters IDLE.
- Reset values:
  - dut_i* = 0, busy = 0, done = 0, pass = 0, errcnt = 0, fail_map = 0.
  - Internal vector index = 0, settle counter = 0.
- IDLE:
  - dut_i* = 000.
  - start=1 and abort=0 → latch settle into settle_q, clear errcnt (and fail_map), vec = 0, counter = 0, go to SETTLE.
- SETTLE:
  - Drive {i2,i1,i0} = vec.
  - Counter increments each cycle; after settle_q+1 cycles in SETTLE, go to CHECK.
- CHECK (one cycle):
  - Expected value = ~(i0 & i1 & i2) of vec, i.e. 0 only for vec = 7.
  - If dut_nq ≠ expected: errcnt += 1, saturating at all-ones.
  - vec = 7 → DONE. Otherwise vec += 1, clear counter, go to SETTLE.
- DONE (one cycle):
  - done = 1.
  - pass = (final errcnt == 0), including any increment from the last CHECK.
  - Then go to IDLE; dut_i* return to 000.
- pass, errcnt and fail_map hold until the next accepted start.
- abort=1 in SETTLE/CHECK/DONE → IDLE at the next edge:
  - dut_i* = 000, no done pulse.
  - pass unchanged; errcnt and fail_map keep their partial values.
- start while busy is ignored. start and abort high together in IDLE → stay in IDLE.
- Reset asserted mid-run: immediate return to reset values, no done pulse.

## Timing

- dut_i* are flops that change on the edge entering SETTLE for a new vector.
- dut_nq is sampled at the end of the CHECK cycle. This gives settle_q+2 cycles of CUT propagation per vector.
- settle = 0 is legal and gives a 1-cycle SETTLE.
- Run latency:
  - start sampled at edge E0 → done high in the cycle following edge E0 + 8·(settle+2).
  - busy rises at E0+1 cycle and falls one cycle after done.
- Back-to-back runs: start may be asserted during the done cycle, but it is only accepted once IDLE is reached, one cycle later.

## Configuration

- CELL_TEST_SEQ_FAILMAP_EN defined:
  - fail_map[7:0] port and register exist.
  - Bit v is set in the CHECK of vector v on mismatch; bits are sticky until start.
  - fail_map does not saturate, and is updated even when errcnt is saturated.
- Not defined: no fail_map port or logic; all other behaviour is identical.

## Test plan

- Ideal NAND3 model on dut_nq, settle=0, start pulse:
  - Vectors 0..7 appear in order, each for 2 cycles.
  - done at E0+16; pass=1, errcnt=0, fail_map=0x00.
- dut_nq stuck at 1, settle=2:
  - done at E0+32; errcnt=1, pass=0, fail_map=0x80.
- dut_nq stuck at 0, ERRCNT_W=2:
  - Seven mismatches; errcnt saturates at 3, pass=0, fail_map=0x7F.
- Ideal model, abort asserted while vec=3 in SETTLE:
  - Next cycle busy=0, dut_i*=000.
  - No done pulse; pass keeps its previous value.
- Ideal model: start re-asserted mid-run is ignored. start with abort in IDLE leaves busy=0. start during the done cycle is not accepted.
- nrst pulsed low while vec=5: all outputs take reset values asynchronously; a subsequent start runs a clean 16-cycle pass with settle=0.

Source files
------------

// File: rtl/cell_test_sequencer.sv
// rtl/cell_test_sequencer.sv - exhaustive NAND3 cell-under-test sequencer with saturating mismatch count
// Define CELL_TEST_SEQ_FAILMAP_EN to add the sticky per-vector fail_map output.
module cell_test_sequencer #(
  parameter int SETTLE_W = 4,
  parameter int ERRCNT_W = 4
) (
  input  logic                ck,
  input  logic                nrst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle,
  output logic                dut_i0,
  output logic                dut_i1,
  output logic                dut_i2,
  input  logic                dut_nq,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERRCNT_W-1:0] errcnt
`ifdef CELL_TEST_SEQ_FAILMAP_EN
  ,
  output logic [7:0]          fail_map
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]          state;
  logic [2:0]          vec;
  logic [SETTLE_W-1:0] cnt;
  logic [SETTLE_W-1:0] settle_q;
  logic                accept;
  logic                exp_nq;
  logic                mismatch;
  logic [ERRCNT_W-1:0] errcnt_nxt;

  assign accept     = (state == IDLE) && start && !abort;
  assign exp_nq     = ~&vec;
  assign mismatch   = (state == CHECK) && !abort && (dut_nq != exp_nq);
  assign errcnt_nxt = (mismatch && (errcnt != '1)) ? errcnt + 1'b1 : errcnt;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // Abort wins over any in-flight check so a partial run never counts its last sample.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state                    <= IDLE;
      vec                      <= '0;
      cnt                      <= '0;
      settle_q                 <= '0;
      errcnt                   <= '0;
      pass                     <= 1'b0;
      {dut_i2, dut_i1, dut_i0} <= 3'b000;
    end else if (abort && (state != IDLE)) begin
      state                    <= IDLE;
      {dut_i2, dut_i1, dut_i0} <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            settle_q                 <= settle;
            errcnt                   <= '0;
            vec                      <= '0;
            cnt                      <= '0;
            {dut_i2, dut_i1, dut_i0} <= 3'b000;
            state                    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == settle_q) state <= CHECK;
          else                 cnt   <= cnt + 1'b1;
        end
        CHECK: begin
          errcnt <= errcnt_nxt;
          if (vec == 3'd7) begin
            pass  <= (errcnt_nxt == '0);
            state <= DONE;
          end else begin
            vec                      <= vec + 3'd1;
            {dut_i2, dut_i1, dut_i0} <= vec + 3'd1;
            cnt                      <= '0;
            state                    <= SETTLE;
          end
        end
        DONE: begin
          {dut_i2, dut_i1, dut_i0} <= 3'b000;
          state                    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CELL_TEST_SEQ_FAILMAP_EN
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst)         fail_map      <= '0;
    else if (accept)   fail_map      <= '0;
    else if (mismatch) fail_map[vec] <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cell_test_sequencer.sv
// tb/tb_cell_test_sequencer.sv - scoreboard bench for cell_test_sequencer
// Two instances: default widths with a switchable CUT model, and ERRCNT_W=2 with the CUT stuck at 0.
module tb_cell_test_sequencer;

  logic       ck = 1'b0;
  logic       nrst;
  logic       start;
  logic       abort;
  logic [3:0] settle;
  logic       i0, i1, i2, nq;
  logic       busy, done, pass;
  logic [3:0] errcnt;
  logic       s_i0, s_i1, s_i2, s_busy, s_done, s_pass;
  logic [1:0] s_errcnt;
`ifdef CELL_TEST_SEQ_FAILMAP_EN
  logic [7:0] fail_map, s_fail_map;
`endif
  int mode;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] err;
    logic       pss;
    logic [7:0] fm;
  } res_t;

  logic [2:0] vec_q[$];
  res_t       res_q[$];

  always #5 ck = ~ck;

  function automatic logic nq_model(input int m, input logic [2:0] v);
    case (m)
      1:       return 1'b1;
      2:       return 1'b0;
      default: return ~&v;
    endcase
  endfunction

  assign nq = nq_model(mode, {i2, i1, i0});

  cell_test_sequencer u_dut (
    .ck(ck), .nrst(nrst), .start(start), .abort(abort), .settle(settle),
    .dut_i0(i0), .dut_i1(i1), .dut_i2(i2), .dut_nq(nq),
    .busy(busy), .done(done), .pass(pass), .errcnt(errcnt)
`ifdef CELL_TEST_SEQ_FAILMAP_EN
    , .fail_map(fail_map)
`endif
  );

  cell_test_sequencer #(.SETTLE_W(4), .ERRCNT_W(2)) u_sat (
    .ck(ck), .nrst(nrst), .start(start), .abort(abort), .settle(settle),
    .dut_i0(s_i0), .dut_i1(s_i1), .dut_i2(s_i2), .dut_nq(1'b0),
    .busy(s_busy), .done(s_done), .pass(s_pass), .errcnt(s_errcnt)
`ifdef CELL_TEST_SEQ_FAILMAP_EN
    , .fail_map(s_fail_map)
`endif
  );

  // Full run: expected vectors and final result are queued up front, then popped as the DUT steps.
  task automatic run(input int s, input int m, input int mid_j, input bit done_start);
    int         n, ec;
    logic [7:0] fm;
    logic [2:0] v, ev;
    res_t       r;
    n  = 8 * (s + 2);
    mode = m;
    ec = 0;
    fm = '0;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      if (nq_model(m, v) !== (k != 7)) begin
        ec++;
        fm[k] = 1'b1;
      end
    end
    r.err = (ec > 15) ? 4'hF : 4'(ec);
    r.pss = (ec == 0);
    r.fm  = fm;
    for (int j = 0; j < n; j++) vec_q.push_back(3'(j / (s + 2)));
    res_q.push_back(r);
    @(negedge ck);
    settle = 4'(s);
    start  = 1'b1;
    for (int j = 0; j <= n + 1 + int'(done_start); j++) begin
      @(negedge ck);
      start = (j == mid_j) || (done_start && (j == n));
      if (j == mid_j) settle = 4'(s + 3);
      total++;
      if (j < n) begin
        ev = vec_q.pop_front();
        if ({i2, i1, i0} !== ev || busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL run_vec s=%0d j=%0d: got vec=%0d busy=%b done=%b, expected vec=%0d busy=1 done=0",
                   s, j, {i2, i1, i0}, busy, done, ev);
        end
      end else if (j == n) begin
        r = res_q.pop_front();
        if (done !== 1'b1 || busy !== 1'b1 || errcnt !== r.err || pass !== r.pss) begin
          bad++;
          $display("FAIL run_done s=%0d m=%0d: got done=%b busy=%b errcnt=%0d pass=%b, expected done=1 busy=1 errcnt=%0d pass=%b",
                   s, m, done, busy, errcnt, pass, r.err, r.pss);
        end
`ifdef CELL_TEST_SEQ_FAILMAP_EN
        total++;
        if (fail_map !== r.fm) begin
          bad++;
          $display("FAIL run_failmap m=%0d: got %h expected %h", m, fail_map, r.fm);
        end
`endif
      end else begin
        if (busy !== 1'b0 || done !== 1'b0 || {i2, i1, i0} !== 3'b000) begin
          bad++;
          $display("FAIL run_idle j=%0d: got busy=%b done=%b vec=%0d, expected busy=0 done=0 vec=0",
                   j, busy, done, {i2, i1, i0});
        end
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; start = 1'b0; abort = 1'b0; settle = '0; mode = 0;
    repeat (2) @(negedge ck);
    total++;
    if ({i2, i1, i0} !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || errcnt !== 4'd0) begin
      bad++;
      $display("FAIL reset: got vec=%0d busy=%b done=%b pass=%b errcnt=%0d, expected all 0",
               {i2, i1, i0}, busy, done, pass, errcnt);
    end
`ifdef CELL_TEST_SEQ_FAILMAP_EN
    total++;
    if (fail_map !== 8'h00) begin
      bad++;
      $display("FAIL reset_failmap: got %h expected 00", fail_map);
    end
`endif
    nrst = 1'b1;
  endtask

  task automatic test_ideal();
    run(0, 0, -1, 1'b0);
  endtask

  task automatic test_stuck1();
    run(2, 1, -1, 1'b0);
  endtask

  task automatic test_stuck0();
    int sec;
    run(1, 2, -1, 1'b0);
    sec = 0;
    for (int k = 0; k < 8; k++) if ((k != 7) !== 1'b0) sec++;
    if (sec > 3) sec = 3;
    total++;
    if (s_errcnt !== 2'(sec) || s_pass !== 1'b0) begin
      bad++;
      $display("FAIL sat_errcnt: got errcnt=%0d pass=%b, expected errcnt=%0d pass=0", s_errcnt, s_pass, sec);
    end
`ifdef CELL_TEST_SEQ_FAILMAP_EN
    total++;
    if (s_fail_map !== 8'h7F) begin
      bad++;
      $display("FAIL sat_failmap: got %h expected 7f", s_fail_map);
    end
`endif
  endtask

  task automatic test_abort();
    bit seen_done;
    run(0, 0, -1, 1'b0);
    mode = 0;
    @(negedge ck);
    settle = 4'd1;
    start  = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      @(negedge ck);
      start = 1'b0;
    end
    total++;
    if ({i2, i1, i0} !== 3'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: got vec=%0d busy=%b, expected vec=3 busy=1", {i2, i1, i0}, busy);
    end
    abort = 1'b1;
    @(negedge ck);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || {i2, i1, i0} !== 3'b000 || done !== 1'b0 || pass !== 1'b1 || errcnt !== 4'd0) begin
      bad++;
      $display("FAIL abort_post: got busy=%b vec=%0d done=%b pass=%b errcnt=%0d, expected 0 0 0 1 0",
               busy, {i2, i1, i0}, done, pass, errcnt);
    end
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge ck);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet: got activity=%b expected 0", seen_done);
    end
  endtask

  task automatic test_ignore();
    run(0, 0, 5, 1'b1);
    @(negedge ck);
    start = 1'b1;
    abort = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge ck);
      total++;
      if (busy !== 1'b0 || s_busy !== 1'b0) begin
        bad++;
        $display("FAIL start_abort_idle j=%0d: got busy=%b/%b expected 0", j, busy, s_busy);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    mode = 2;
    @(negedge ck);
    settle = 4'd0;
    start  = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge ck);
      start = 1'b0;
    end
    total++;
    if ({i2, i1, i0} !== 3'd5 || errcnt !== 4'd5 || pass !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre: got vec=%0d errcnt=%0d pass=%b, expected 5 5 1", {i2, i1, i0}, errcnt, pass);
    end
    nrst = 1'b0;
    #1;
    total++;
    if ({i2, i1, i0} !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || errcnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_async: got vec=%0d busy=%b done=%b pass=%b errcnt=%0d, expected all 0",
               {i2, i1, i0}, busy, done, pass, errcnt);
    end
`ifdef CELL_TEST_SEQ_FAILMAP_EN
    total++;
    if (fail_map !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_failmap: got %h expected 00", fail_map);
    end
`endif
    @(negedge ck);
    nrst = 1'b1;
    run(0, 0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck1();
    test_stuck0();
    test_abort();
    test_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
